// File: rtl/spike_rate_decoder.sv
// -----------------------------------------------------------------------------
// spike_rate_decoder
//
// Turns a spike train from a LIF neuron into two measurements:
//   * a firing rate: the number of 0->1 edges counted over a fixed window of
//     2^WIN_LOG2 cycles, published once per window with a one-cycle valid pulse
//   * an inter-spike interval: the number of cycles between the two most recent
//     edges, updated on every edge
//
// Ports
//   clk       in   single clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   spike_in  in   spike line, synchronous to clk
//   enable    in   1 = measure, 0 = idle / abort the current window
//   rate      out  [CNT_W] edges counted in the last completed window (saturating)
//   isi       out  [CNT_W] cycles between the two most recent edges (saturating)
//   valid     out  one-cycle pulse, new rate/overflow result
//   overflow  out  the last completed window saturated its spike count
//   busy      out  a window is being measured (COUNT or REPORT)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module spike_rate_decoder #(
  parameter int WIN_LOG2 = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spike_in,
  input  logic             enable,
  output logic [CNT_W-1:0] rate,
  output logic [CNT_W-1:0] isi,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);

  localparam logic [CNT_W-1:0]    CNT_MAX  = '1;
  localparam logic [WIN_LOG2-1:0] WIN_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COUNT  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                spk_q;
  logic                spk_edge;
  logic [WIN_LOG2-1:0] win_q, win_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sat_q, sat_d;
  logic [CNT_W-1:0]    rate_q, rate_d;
  logic                ovf_q, ovf_d;
  logic [CNT_W-1:0]    isi_cnt_q, isi_cnt_d;
  logic [CNT_W-1:0]    isi_q, isi_d;
  logic                isi_arm_q, isi_arm_d;

  // Spike counter value including this cycle's edge, and whether that edge
  // arrived while the counter was already pinned at its maximum.
  logic [CNT_W-1:0]    cnt_inc;
  logic                sat_hit;

  assign spk_edge = spike_in & ~spk_q;
  assign sat_hit  = spk_edge && (cnt_q == CNT_MAX);
  assign cnt_inc  = (spk_edge && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      spk_q     <= 1'b0;
      win_q     <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      rate_q    <= '0;
      ovf_q     <= 1'b0;
      isi_cnt_q <= '0;
      isi_q     <= '0;
      isi_arm_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      spk_q     <= spike_in;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      rate_q    <= rate_d;
      ovf_q     <= ovf_d;
      isi_cnt_q <= isi_cnt_d;
      isi_q     <= isi_d;
      isi_arm_q <= isi_arm_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and window datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    rate_d  = rate_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        win_d = '0;
        cnt_d = '0;
        sat_d = 1'b0;
        if (enable) state_d = S_COUNT;
      end

      S_COUNT: begin
        if (!enable) begin
          // Abort: drop the partial window, results keep their old values.
          state_d = S_IDLE;
          win_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end else begin
          win_d = win_q + 1'b1;
          cnt_d = cnt_inc;
          sat_d = sat_q | sat_hit;
          if (win_q == WIN_LAST) begin
            // Results are loaded on the way into REPORT so they are already
            // visible while valid is high; the last-cycle edge is included.
            state_d = S_REPORT;
            win_d   = '0;
            rate_d  = cnt_inc;
            ovf_d   = sat_q | sat_hit;
          end
        end
      end

      S_REPORT: begin
        win_d = '0;
        sat_d = 1'b0;
        if (enable) begin
          // An edge seen during REPORT opens the next window's count.
          state_d = S_COUNT;
          cnt_d   = spk_edge ? CNT_W'(1) : '0;
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        win_d   = '0;
        cnt_d   = '0;
        sat_d   = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Inter-spike interval, independent of the window FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    isi_cnt_d = isi_cnt_q;
    isi_d     = isi_q;
    isi_arm_d = isi_arm_q;

    if (!enable) begin
      // Disarm so the first edge after re-enable only restarts the count.
      isi_cnt_d = '0;
      isi_arm_d = 1'b0;
    end else if (spk_edge) begin
      if (isi_arm_q) begin
        isi_d = (isi_cnt_q == CNT_MAX) ? CNT_MAX : isi_cnt_q + 1'b1;
      end
      isi_cnt_d = '0;
      isi_arm_d = 1'b1;
    end else if (isi_cnt_q != CNT_MAX) begin
      isi_cnt_d = isi_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    valid    = (state_q == S_REPORT);
    busy     = (state_q != S_IDLE);
    rate     = rate_q;
    overflow = ovf_q;
    isi      = isi_q;
  end

endmodule
